// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one shift per clock).
// Optional leading-zero blank mask: define PRODUCT_BCD_LEADING_ZERO_BLANK_EN.
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Product_In,
  output logic [4*DIGITS-1:0]   BCD_Out,
  output logic                  Neg,
  output logic [DIGITS-1:0]     Blank,
  output logic                  Busy,
  output logic                  Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic              sign_q, sign_d;
  logic [SW-1:0]     bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              done_q, done_d;

  logic              in_neg;
  logic [WIDTH:0]    in_ext;
  logic [WIDTH:0]    in_mag;
  logic [SW-1:0]     scratch_adj;
  logic [SW-1:0]     scratch_sh;
  logic [WIDTH-1:0]  mag_sh;
  logic [DIGITS-1:0] blank_mask;

  // Sign-extend to WIDTH+1 bits so the most negative input negates cleanly.
  assign in_neg = (SIGNED != 0) && Product_In[WIDTH-1];
  assign in_ext = {in_neg, Product_In};
  assign in_mag = in_neg ? (~in_ext + 1'b1) : in_ext;

  always_comb begin
    scratch_adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
  end

  assign {scratch_sh, mag_sh} = {scratch_adj, mag_q} << 1;

`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
  always_comb begin : blank_calc
    logic hi_zero;
    hi_zero    = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero       = hi_zero && (scratch_sh[4*i +: 4] == 4'd0);
      blank_mask[i] = hi_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Handshake: Start is accepted only while Busy=0 (IDLE); Busy stays high
  // through SHIFT and DONE; Done pulses for one cycle as the outputs update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scratch_d = scratch_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    blank_d   = blank_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_SHIFT;
          cnt_d     = '0;
          scratch_d = '0;
          mag_d     = in_mag[WIDTH-1:0];
          sign_d    = in_neg && (|in_mag);
        end
      end
      S_SHIFT: begin
        scratch_d = scratch_sh;
        mag_d     = mag_sh;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Outputs load on the final shift edge so they appear with Done.
          state_d = S_DONE;
          bcd_d   = scratch_sh;
          neg_d   = sign_q;
          blank_d = blank_mask;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      scratch_q <= '0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      blank_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      blank_q   <= blank_d;
      done_q    <= done_d;
    end
  end

  assign BCD_Out = bcd_q;
  assign Neg     = neg_q;
  assign Blank   = blank_q;
  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;

endmodule
